// File: rtl/fighter_pkg.sv
// Shared encodings and helpers for the fighter movement controller.
package fighter_pkg;

  localparam logic [1:0] CS_IDLE    = 2'b00;
  localparam logic [1:0] CS_ATTACK  = 2'b01;
  localparam logic [1:0] CS_SPECIAL = 2'b10;

  localparam int SCREEN_W = 96;
  localparam int SCREEN_H = 64;

  typedef enum logic [1:0] {
    ST_GROUND  = 2'd0,
    ST_AIR     = 2'd1,
    ST_ATTACK  = 2'd2,
    ST_SPECIAL = 2'd3
  } fsm_state_e;

  // Saturate a signed intermediate coordinate into an unsigned 7-bit range.
  function automatic logic [6:0] clamp_u7(input logic signed [7:0] v,
                                          input logic [6:0] lo,
                                          input logic [6:0] hi);
    logic signed [7:0] lo_s;
    logic signed [7:0] hi_s;
    lo_s = $signed({1'b0, lo});
    hi_s = $signed({1'b0, hi});
    if (v < lo_s)      return lo;
    else if (v > hi_s) return hi;
    else               return v[6:0];
  endfunction

endpackage

// File: rtl/fighter_motion_ctrl_combo_detector.sv
// Tracks the left, down, right edge sequence that arms the special move.
module combo_detector
  import fighter_pkg::*;
#(
  parameter int COMBO_WINDOW = 10
) (
  input  logic clk,
  input  logic reset,
  input  logic frame_tick,
  input  logic left_edge,
  input  logic down_edge,
  input  logic right_edge,
  input  logic consume,
  output logic armed
);

  localparam int CW = $clog2(COMBO_WINDOW + 1);
  localparam logic [CW-1:0] WIN_FULL = CW'(COMBO_WINDOW);

  logic [1:0]    prog_q, prog_d;
  logic [CW-1:0] win_q, win_d;
  logic [1:0]    prog_eff;
  logic          expected_hit;
  logic          any_edge;

  always_comb begin
    // An expired window means progress no longer counts, even before it is cleared.
    prog_eff = (win_q == '0) ? 2'd0 : prog_q;
    any_edge = left_edge | down_edge | right_edge;
    case (prog_eff)
      2'd0:    expected_hit = left_edge  & ~down_edge & ~right_edge;
      2'd1:    expected_hit = down_edge  & ~left_edge & ~right_edge;
      2'd2:    expected_hit = right_edge & ~left_edge & ~down_edge;
      default: expected_hit = 1'b0;
    endcase

    prog_d = prog_q;
    win_d  = win_q;
    if (frame_tick) begin
      if (consume) begin
        prog_d = 2'd0;
        win_d  = '0;
      end else if (expected_hit) begin
        prog_d = prog_eff + 2'd1;
        win_d  = WIN_FULL;
      end else if (any_edge) begin
        prog_d = left_edge ? 2'd1 : 2'd0;
        win_d  = left_edge ? WIN_FULL : '0;
      end else if (win_q != '0) begin
        win_d = win_q - 1'b1;
      end else begin
        prog_d = 2'd0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      prog_q <= 2'd0;
      win_q  <= '0;
    end else begin
      prog_q <= prog_d;
      win_q  <= win_d;
    end
  end

  assign armed = (prog_q == 2'd3) && (win_q != '0);

endmodule

// File: rtl/fighter_motion_ctrl.sv
// Per-fighter movement/attack controller; every state update happens on frame_tick.
module fighter_motion_ctrl
  import fighter_pkg::*;
#(
  parameter int X_MIN         = 8,
  parameter int X_MAX         = 88,
  parameter int Y_GROUND      = 32,
  parameter int START_X       = 24,
  parameter bit START_MIRROR  = 1'b0,
  parameter int WALK_STEP     = 2,
  parameter int JUMP_V0       = 6,
  parameter int GRAVITY       = 1,
  parameter int ATTACK_TICKS  = 9,
  parameter int SPECIAL_TICKS = 15,
  parameter int COMBO_WINDOW  = 10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       frame_tick,
  input  logic       btn_left,
  input  logic       btn_right,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       btn_attack,
  input  logic [6:0] opponent_x,
  output logic [6:0] x,
  output logic [6:0] y,
  output logic       in_air,
  output logic       is_moving,
  output logic [1:0] character_state,
  output logic       mirror
);

  localparam int X_HI      = (X_MAX < SCREEN_W) ? X_MAX : SCREEN_W - 1;
  localparam int Y_GND     = (Y_GROUND < SCREEN_H) ? Y_GROUND : SCREEN_H - 1;
  localparam int MAX_TICKS = (ATTACK_TICKS > SPECIAL_TICKS) ? ATTACK_TICKS : SPECIAL_TICKS;
  localparam int CNT_W     = $clog2(MAX_TICKS + 1);

  localparam logic [6:0]        X_LO7    = 7'(X_MIN);
  localparam logic [6:0]        X_HI7    = 7'(X_HI);
  localparam logic [6:0]        Y_GND7   = 7'(Y_GND);
  localparam logic [6:0]        START_X7 = 7'(START_X);
  localparam logic signed [7:0] STEP     = 8'(WALK_STEP);
  localparam logic signed [5:0] VY_JUMP  = 6'(-JUMP_V0);
  localparam logic signed [5:0] VY_GRAV  = 6'(GRAVITY);
  localparam logic [CNT_W-1:0]  ATK_LOAD = CNT_W'(ATTACK_TICKS - 1);
  localparam logic [CNT_W-1:0]  SPC_LOAD = CNT_W'(SPECIAL_TICKS - 1);

  fsm_state_e        st_q, st_d;
  logic [6:0]        x_q, x_d, y_q, y_d;
  logic signed [5:0] vy_q, vy_d;
  logic              in_air_q, in_air_d, moving_q, moving_d, mirror_q, mirror_d;
  logic [1:0]        cs_q, cs_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [4:0]        prev_q, prev_d;

  logic [4:0]        btn_now, edges;
  logic              left_e, right_e, up_e, down_e, atk_e;
  logic              armed;
  logic signed [7:0] walk_delta, y_sum;
  logic [6:0]        x_walk;

  assign btn_now = {btn_left, btn_right, btn_up, btn_down, btn_attack};
  assign edges   = btn_now & ~prev_q;
  assign {left_e, right_e, up_e, down_e, atk_e} = edges;

  combo_detector #(.COMBO_WINDOW(COMBO_WINDOW)) u_combo (
    .clk        (clk),
    .reset      (reset),
    .frame_tick (frame_tick),
    .left_edge  (left_e),
    .down_edge  (down_e),
    .right_edge (right_e),
    .consume    (atk_e),
    .armed      (armed)
  );

  always_comb begin
    walk_delta = 8'sd0;
    if (btn_left && !btn_right)      walk_delta = -STEP;
    else if (btn_right && !btn_left) walk_delta = STEP;
    x_walk = clamp_u7($signed({1'b0, x_q}) + walk_delta, X_LO7, X_HI7);
    y_sum  = $signed({1'b0, y_q}) + $signed({{2{vy_q[5]}}, vy_q});

    st_d     = st_q;
    x_d      = x_q;
    y_d      = y_q;
    vy_d     = vy_q;
    in_air_d = in_air_q;
    moving_d = moving_q;
    mirror_d = mirror_q;
    cs_d     = cs_q;
    cnt_d    = cnt_q;
    prev_d   = prev_q;

    if (frame_tick) begin
      prev_d   = btn_now;
      moving_d = 1'b0;
      case (st_q)
        ST_GROUND: begin
          if (opponent_x < x_q)      mirror_d = 1'b1;
          else if (opponent_x > x_q) mirror_d = 1'b0;
          if (atk_e) begin
            st_d  = armed ? ST_SPECIAL : ST_ATTACK;
            cs_d  = armed ? CS_SPECIAL : CS_ATTACK;
            cnt_d = armed ? SPC_LOAD : ATK_LOAD;
          end else if (up_e) begin
            st_d     = ST_AIR;
            in_air_d = 1'b1;
            vy_d     = VY_JUMP;
          end else begin
            x_d      = x_walk;
            moving_d = (x_walk != x_q);
          end
        end
        ST_AIR: begin
          x_d = x_walk;
          if (y_sum >= $signed({1'b0, Y_GND7})) begin
            y_d      = Y_GND7;
            vy_d     = 6'sd0;
            in_air_d = 1'b0;
            st_d     = ST_GROUND;
          end else begin
            y_d  = clamp_u7(y_sum, 7'd0, Y_GND7);
            vy_d = vy_q + VY_GRAV;
          end
        end
        default: begin
          if (cnt_q == '0) begin
            st_d = ST_GROUND;
            cs_d = CS_IDLE;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      st_q     <= ST_GROUND;
      x_q      <= START_X7;
      y_q      <= Y_GND7;
      vy_q     <= 6'sd0;
      in_air_q <= 1'b0;
      moving_q <= 1'b0;
      mirror_q <= START_MIRROR;
      cs_q     <= CS_IDLE;
      cnt_q    <= '0;
      prev_q   <= 5'd0;
    end else begin
      st_q     <= st_d;
      x_q      <= x_d;
      y_q      <= y_d;
      vy_q     <= vy_d;
      in_air_q <= in_air_d;
      moving_q <= moving_d;
      mirror_q <= mirror_d;
      cs_q     <= cs_d;
      cnt_q    <= cnt_d;
      prev_q   <= prev_d;
    end
  end

  assign x               = x_q;
  assign y               = y_q;
  assign in_air          = in_air_q;
  assign is_moving       = moving_q;
  assign character_state = cs_q;
  assign mirror          = mirror_q;

endmodule

// File: tb/tb_fighter_motion_ctrl.sv
// Directed bench for fighter_motion_ctrl: a per-tick vector table plus multi-tick sequences.
module tb_fighter_motion_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       frame_tick = 1'b0;
  logic       btn_left = 1'b0, btn_right = 1'b0, btn_up = 1'b0, btn_down = 1'b0, btn_attack = 1'b0;
  logic [6:0] opponent_x = 7'd60;
  logic [6:0] x, y;
  logic       in_air, is_moving, mirror;
  logic [1:0] character_state;

  int total = 0;
  int bad = 0;

  fighter_motion_ctrl dut (
    .clk             (clk),
    .reset           (reset),
    .frame_tick      (frame_tick),
    .btn_left        (btn_left),
    .btn_right       (btn_right),
    .btn_up          (btn_up),
    .btn_down        (btn_down),
    .btn_attack      (btn_attack),
    .opponent_x      (opponent_x),
    .x               (x),
    .y               (y),
    .in_air          (in_air),
    .is_moving       (is_moving),
    .character_state (character_state),
    .mirror          (mirror)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       l, r, u, d, a;
    logic [6:0] opp;
    logic [6:0] ex, ey;
    logic       eair, emov;
    logic [1:0] ecs;
    logic       emir;
  } vec_t;

  vec_t vecs[23];

  function automatic vec_t mk(input int l, r, u, d, a, opp, ex, ey, eair, emov, ecs, emir);
    vec_t v;
    v.l = l[0]; v.r = r[0]; v.u = u[0]; v.d = d[0]; v.a = a[0];
    v.opp = 7'(opp); v.ex = 7'(ex); v.ey = 7'(ey);
    v.eair = eair[0]; v.emov = emov[0]; v.ecs = 2'(ecs); v.emir = emir[0];
    return v;
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  // Called at a negedge; one frame_tick strobe, returns at the following negedge.
  task automatic do_tick(input logic l, r, u, d, a);
    btn_left = l; btn_right = r; btn_up = u; btn_down = d; btn_attack = a;
    frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
    @(negedge clk);
  endtask

  task automatic do_reset();
    btn_left = 0; btn_right = 0; btn_up = 0; btn_down = 0; btn_attack = 0;
    frame_tick = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic run_combo(input string nm, input int gap, input int exp_cs, input int exp_len);
    int n;
    do_reset();
    do_tick(1, 0, 0, 0, 0);
    do_tick(0, 0, 0, 0, 0);
    do_tick(0, 0, 0, 0, 0);
    do_tick(0, 0, 0, 1, 0);
    do_tick(0, 0, 0, 0, 0);
    do_tick(0, 0, 0, 0, 0);
    do_tick(0, 1, 0, 0, 0);
    for (int i = 1; i < gap; i++) do_tick(0, 0, 0, 0, 0);
    do_tick(0, 0, 0, 0, 1);
    chk({nm, "_state"}, character_state, exp_cs);
    n = 1;
    for (int i = 0; i < 40; i++) begin
      do_tick(0, 0, 0, 0, 0);
      if (character_state == 2'(exp_cs)) n++;
      else break;
    end
    chk({nm, "_len"}, n, exp_len);
    chk({nm, "_idle"}, character_state, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n;
    //                l  r  u  d  a  opp  x   y  air mov cs mir
    vecs[0]  = mk(0, 0, 0, 0, 0, 60, 24, 32, 0, 0, 0, 0);
    vecs[1]  = mk(0, 1, 0, 0, 0, 60, 26, 32, 0, 1, 0, 0);
    vecs[2]  = mk(0, 1, 0, 0, 0, 60, 28, 32, 0, 1, 0, 0);
    vecs[3]  = mk(1, 1, 0, 0, 0, 60, 28, 32, 0, 0, 0, 0);
    vecs[4]  = mk(1, 0, 0, 0, 0, 60, 26, 32, 0, 1, 0, 0);
    vecs[5]  = mk(0, 0, 0, 0, 0, 10, 26, 32, 0, 0, 0, 1);
    vecs[6]  = mk(0, 0, 0, 0, 0, 26, 26, 32, 0, 0, 0, 1);
    vecs[7]  = mk(0, 0, 0, 0, 0, 60, 26, 32, 0, 0, 0, 0);
    vecs[8]  = mk(0, 0, 1, 0, 0, 60, 26, 32, 1, 0, 0, 0);
    vecs[9]  = mk(0, 1, 0, 0, 0, 60, 28, 26, 1, 0, 0, 0);
    vecs[10] = mk(1, 0, 0, 0, 0, 60, 26, 21, 1, 0, 0, 0);
    vecs[11] = mk(0, 0, 0, 0, 0, 10, 26, 17, 1, 0, 0, 0);
    vecs[12] = mk(0, 0, 0, 0, 0, 10, 26, 14, 1, 0, 0, 0);
    vecs[13] = mk(0, 0, 0, 0, 0, 10, 26, 12, 1, 0, 0, 0);
    vecs[14] = mk(0, 0, 0, 0, 0, 10, 26, 11, 1, 0, 0, 0);
    vecs[15] = mk(0, 0, 0, 0, 0, 10, 26, 11, 1, 0, 0, 0);
    vecs[16] = mk(0, 0, 0, 0, 0, 10, 26, 12, 1, 0, 0, 0);
    vecs[17] = mk(0, 0, 0, 0, 0, 10, 26, 14, 1, 0, 0, 0);
    vecs[18] = mk(0, 0, 0, 0, 0, 10, 26, 17, 1, 0, 0, 0);
    vecs[19] = mk(0, 0, 0, 0, 0, 10, 26, 21, 1, 0, 0, 0);
    vecs[20] = mk(0, 0, 0, 0, 0, 10, 26, 26, 1, 0, 0, 0);
    vecs[21] = mk(0, 0, 0, 0, 0, 10, 26, 32, 0, 0, 0, 0);
    vecs[22] = mk(0, 0, 0, 0, 0, 10, 26, 32, 0, 0, 0, 1);

    @(negedge clk);
    @(negedge clk);
    do_reset();
    chk("rst_x", x, 24);
    chk("rst_y", y, 32);
    chk("rst_air", in_air, 0);
    chk("rst_mov", is_moving, 0);
    chk("rst_cs", character_state, 0);
    chk("rst_mir", mirror, 0);

    for (int i = 0; i < 23; i++) begin
      opponent_x = vecs[i].opp;
      do_tick(vecs[i].l, vecs[i].r, vecs[i].u, vecs[i].d, vecs[i].a);
      chk($sformatf("v%0d_x", i), x, vecs[i].ex);
      chk($sformatf("v%0d_y", i), y, vecs[i].ey);
      chk($sformatf("v%0d_air", i), in_air, vecs[i].eair);
      chk($sformatf("v%0d_mov", i), is_moving, vecs[i].emov);
      chk($sformatf("v%0d_cs", i), character_state, vecs[i].ecs);
      chk($sformatf("v%0d_mir", i), mirror, vecs[i].emir);
    end

    // Walk into the right wall, then back into the left wall.
    do_reset();
    opponent_x = 7'd100;
    for (int k = 1; k <= 50; k++) begin
      do_tick(0, 1, 0, 0, 0);
      if (k == 10) begin
        repeat (3) @(negedge clk);
        chk("hold_no_tick_x", x, 44);
      end
      if (k == 32) begin
        chk("wall_r_x32", x, 88);
        chk("wall_r_mov32", is_moving, 1);
      end
      if (k == 33) chk("wall_r_mov33", is_moving, 0);
    end
    chk("wall_r_x50", x, 88);
    do_tick(1, 1, 0, 0, 0);
    chk("both_mov", is_moving, 0);
    chk("both_x", x, 88);
    for (int k = 1; k <= 41; k++) begin
      do_tick(1, 0, 0, 0, 0);
      if (k == 40) begin
        chk("wall_l_x40", x, 8);
        chk("wall_l_mov40", is_moving, 1);
      end
    end
    chk("wall_l_x41", x, 8);
    chk("wall_l_mov41", is_moving, 0);

    // Attack: 9 ticks at 01, x and mirror frozen, second edge ignored.
    do_reset();
    opponent_x = 7'd60;
    do_tick(0, 1, 0, 0, 1);
    chk("atk_entry_cs", character_state, 1);
    chk("atk_entry_x", x, 24);
    n = 1;
    opponent_x = 7'd10;
    for (int i = 1; i <= 12; i++) begin
      do_tick(0, 1, 0, 0, (i == 3) ? 1'b1 : 1'b0);
      if (character_state == 2'b01) n++;
      else break;
    end
    chk("atk_len", n, 9);
    chk("atk_frozen_x", x, 24);
    chk("atk_frozen_mir", mirror, 0);
    do_tick(0, 1, 0, 0, 0);
    chk("atk_after_x", x, 26);
    chk("atk_after_mir", mirror, 1);

    // Combo timing: gap measured from the right edge to the attack edge.
    run_combo("combo3", 3, 2, 15);
    run_combo("combo10", 10, 2, 15);
    run_combo("combo11", 11, 1, 9);

    // Out-of-order sequence: L, D, L (restart), R (breaks it) -> plain attack.
    do_reset();
    do_tick(1, 0, 0, 0, 0);
    do_tick(0, 0, 0, 1, 0);
    do_tick(1, 0, 0, 0, 0);
    do_tick(0, 1, 0, 0, 0);
    do_tick(0, 0, 0, 0, 1);
    chk("combo_order_cs", character_state, 1);

    // Reset in the middle of a jump with mirror set.
    do_reset();
    opponent_x = 7'd10;
    do_tick(0, 0, 0, 0, 0);
    chk("mj_mir_pre", mirror, 1);
    do_tick(0, 0, 1, 0, 0);
    do_tick(0, 0, 0, 0, 0);
    do_tick(0, 0, 0, 0, 0);
    chk("mj_y_pre", y, 21);
    do_reset();
    chk("mj_y", y, 32);
    chk("mj_x", x, 24);
    chk("mj_air", in_air, 0);
    chk("mj_cs", character_state, 0);
    chk("mj_mir", mirror, 0);
    opponent_x = 7'd60;
    do_tick(0, 0, 0, 0, 0);
    chk("mj_after_y", y, 32);
    chk("mj_after_air", in_air, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
